// File: rtl/tmr_io_dmr_reg.sv
// Register with DMR-protected state and TMR-facing IO: voted input, two parity-protected copies,
// repair FSM. Optional saturating error counter enabled by TMR_IO_DMR_REG_ERR_CNT_EN.
module tmr_io_dmr_reg #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned CntWidth  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataWidth-1:0] data_a_i,
    input  logic [DataWidth-1:0] data_b_i,
    input  logic [DataWidth-1:0] data_c_i,
    output logic [DataWidth-1:0] data_a_o,
    output logic [DataWidth-1:0] data_b_o,
    output logic [DataWidth-1:0] data_c_o,
    input  logic                 no_load_i,
    output logic                 in_err_o,
    output logic                 state_err_o,
    output logic                 fault_o,
    output logic [CntWidth-1:0]  err_cnt_o,
    input  logic                 err_cnt_clr_i,
    input  logic [DataWidth-1:0] reset_value_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REPAIR = 2'd1,
        FAULT  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [DataWidth-1:0] q0_q, q0_d, q1_q, q1_d;
    logic                 p0_q, p0_d, p1_q, p1_d;
    logic                 state_err_q, fault_q;
    logic                 cnt_inc;

    logic [DataWidth-1:0] voted;
    logic [DataWidth-1:0] sel;
    logic                 ok0, ok1, differ, mis;

    // Input vote and state-health decode
    assign voted    = (data_a_i & data_b_i) | (data_b_i & data_c_i) | (data_a_i & data_c_i);
    assign in_err_o = (data_a_i != data_b_i) | (data_b_i != data_c_i);

    assign ok0    = ((^q0_q) == p0_q);
    assign ok1    = ((^q1_q) == p1_q);
    assign differ = (q0_q != q1_q);
    assign mis    = differ | !ok0 | !ok1;
    assign sel    = (!ok0 && ok1) ? q1_q : q0_q;

    assign data_a_o    = sel;
    assign data_b_o    = sel;
    assign data_c_o    = sel;
    assign state_err_o = state_err_q;
    assign fault_o     = fault_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            q0_q        <= reset_value_i;
            q1_q        <= reset_value_i;
            p0_q        <= ^reset_value_i;
            p1_q        <= ^reset_value_i;
            state_err_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            state_err_q <= mis;
            fault_q     <= (state_d == FAULT);
        end
    end

    // Next state: a load always wins and returns to IDLE; otherwise detect, repair, re-verify
    always_comb begin
        state_d = state_q;
        q0_d    = q0_q;
        q1_d    = q1_q;
        p0_d    = p0_q;
        p1_d    = p1_q;
        cnt_inc = 1'b0;

        if (!no_load_i) begin
            q0_d    = voted;
            q1_d    = voted;
            p0_d    = ^voted;
            p1_d    = ^voted;
            state_d = IDLE;
            cnt_inc = (state_q == IDLE) && mis;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mis && (ok0 || ok1) && !(ok0 && ok1 && differ)) begin
                        q0_d    = sel;
                        q1_d    = sel;
                        p0_d    = ^sel;
                        p1_d    = ^sel;
                        state_d = REPAIR;
                        cnt_inc = 1'b1;
                    end else if (mis) begin
                        state_d = FAULT;
                        cnt_inc = 1'b1;
                    end
                end
                REPAIR: begin
                    if (mis) begin
                        state_d = FAULT;
                        cnt_inc = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                FAULT:   state_d = FAULT;
                default: state_d = FAULT;
            endcase
        end
    end

`ifdef TMR_IO_DMR_REG_ERR_CNT_EN
    logic [CntWidth-1:0] cnt_q;

    // Saturating event counter; clear beats a simultaneous increment
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (err_cnt_clr_i) begin
            cnt_q <= '0;
        end else if (cnt_inc && (cnt_q != {CntWidth{1'b1}})) begin
            cnt_q <= cnt_q + CntWidth'(1);
        end
    end

    assign err_cnt_o = cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = err_cnt_clr_i ^ cnt_inc;
    assign err_cnt_o  = '0;
`endif

endmodule
